jpeg_quant: RTL

JPEG_QUANT -- requirements
Module: jpeg_quant

---
 rtl/jpeg_pkg.sv | 19 +
 rtl/jpeg_quant_if.sv | 27 ++
 rtl/jpeg_sdiv.sv | 72 +++++++
 rtl/jpeg_quant.sv | 108 ++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants, FSM encoding and saturation bounds for the JPEG quantizer.
package jpeg_pkg;

  localparam int COEF_W     = 12;
  localparam int QT_W       = 8;
  localparam int BLK_SIZE   = 64;
  localparam int DIV_CYCLES = 12;
  localparam int CNT_W      = $clog2(BLK_SIZE);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LDQ  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_OUT  = 2'd3;

  localparam int SAT_MAX = (1 << (COEF_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (COEF_W - 1));

endpackage

// File: rtl/jpeg_quant_if.sv
// Coefficient stream, qtable fetch and quantized output bundle of jpeg_quant.
interface jpeg_quant_if;

  logic signed [jpeg_pkg::COEF_W-1:0] din;
  logic                               din_vld;
  logic                               din_rdy;
  logic                               comp_sel;
  logic                               qnt_lum_qtable_rd;
  logic                               qnt_chr_qtable_rd;
  logic [jpeg_pkg::QT_W-1:0]          lum_qtable_data;
  logic [jpeg_pkg::QT_W-1:0]          chr_qtable_data;
  logic signed [jpeg_pkg::COEF_W-1:0] dout;
  logic                               dout_vld;
  logic                               dout_rdy;
  logic                               dout_last;

  modport slave (
    input  din, din_vld, comp_sel, lum_qtable_data, chr_qtable_data, dout_rdy,
    output din_rdy, qnt_lum_qtable_rd, qnt_chr_qtable_rd, dout, dout_vld, dout_last
  );

  modport master (
    output din, din_vld, comp_sel, lum_qtable_data, chr_qtable_data, dout_rdy,
    input  din_rdy, qnt_lum_qtable_rd, qnt_chr_qtable_rd, dout, dout_vld, dout_last
  );

endinterface

// File: rtl/jpeg_sdiv.sv
// Serial restoring divider: one quotient bit per cycle for DIV_CYCLES cycles after start.
module jpeg_sdiv
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COEF_W-1:0] dividend,
  input  logic [QT_W-1:0]   divisor,
  output logic              done,
  output logic [COEF_W-1:0] quotient,
  output logic [QT_W-1:0]   remainder,
  output logic [QT_W-1:0]   divisor_eff
);

  localparam int CYC_W = $clog2(DIV_CYCLES + 1);

  logic [COEF_W-1:0] quo_q, quo_d;
  logic [QT_W-1:0]   rem_q, rem_d, dvs_q, dvs_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              busy_q, busy_d;
  logic [QT_W:0]     trial;
  logic [QT_W-1:0]   diff;
  logic              fits;

  always_comb begin
    trial  = {rem_q, quo_q[COEF_W-1]};
    fits   = trial >= {1'b0, dvs_q};
    // The true difference is below the divisor, so the low bits are exact.
    diff   = trial[QT_W-1:0] - dvs_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cyc_d  = cyc_q;
    busy_d = busy_q;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = (divisor == '0) ? QT_W'(1) : divisor;
      cyc_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = fits ? diff : trial[QT_W-1:0];
      quo_d = {quo_q[COEF_W-2:0], fits};
      cyc_d = cyc_q + CYC_W'(1);
      if (cyc_q == CYC_W'(DIV_CYCLES - 1))
        busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= QT_W'(1);
      cyc_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cyc_q  <= cyc_d;
      busy_q <= busy_d;
    end
  end

  assign done        = busy_q && (cyc_q == CYC_W'(DIV_CYCLES - 1));
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign divisor_eff = dvs_q;

endmodule

// File: rtl/jpeg_quant.sv
// JPEG coefficient quantizer: one coefficient at a time, divided by its qtable entry.
// Define JPEG_QNT_ROUND_EN for round-half-away-from-zero; default build truncates.
module jpeg_quant
  import jpeg_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  jpeg_quant_if.slave  bus
);

  state_t                   state_q, state_d;
  logic signed [COEF_W-1:0] din_q, din_d;
  logic                     sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     din_rdy, in_xfer, eff_sel, div_start, div_done;
  logic [COEF_W-1:0]        dividend, quo;
  logic [QT_W-1:0]          qt_data, rem, dvs;
  logic [COEF_W:0]          mag;
  logic signed [COEF_W+1:0] res;
  logic signed [COEF_W-1:0] sat;

  always_comb begin
    // Gated by rst so nothing handshakes while the block is held in reset.
    din_rdy   = (state_q == ST_IDLE) && !rst;
    in_xfer   = bus.din_vld && din_rdy;
    eff_sel   = (cnt_q == '0) ? bus.comp_sel : sel_q;
    div_start = (state_q == ST_LDQ);
    qt_data   = sel_q ? bus.chr_qtable_data : bus.lum_qtable_data;
    dividend  = din_q[COEF_W-1] ? COEF_W'(-din_q) : COEF_W'(din_q);
  end

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (in_xfer) begin
        din_d   = bus.din;
        sel_d   = eff_sel;
        state_d = ST_LDQ;
      end
      ST_LDQ:  state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_OUT;
      ST_OUT:  if (bus.dout_rdy) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      din_q   <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  jpeg_sdiv u_sdiv (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .dividend    (dividend),
    .divisor     (qt_data),
    .done        (div_done),
    .quotient    (quo),
    .remainder   (rem),
    .divisor_eff (dvs)
  );

`ifndef JPEG_QNT_ROUND_EN
  logic unused_div;
  assign unused_div = ^{rem, dvs};
`endif

  always_comb begin
    mag = {1'b0, quo};
`ifdef JPEG_QNT_ROUND_EN
    if ({rem, 1'b0} >= {1'b0, dvs})
      mag = mag + (COEF_W + 1)'(1);
`endif
    res = din_q[COEF_W-1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    if (res > SAT_MAX)
      sat = COEF_W'(SAT_MAX);
    else if (res < SAT_MIN)
      sat = COEF_W'(SAT_MIN);
    else
      sat = res[COEF_W-1:0];
  end

  // Divider registers hold after the last step, so dout is stable through stalls.
  assign bus.din_rdy           = din_rdy;
  assign bus.qnt_lum_qtable_rd = in_xfer && !eff_sel;
  assign bus.qnt_chr_qtable_rd = in_xfer && eff_sel;
  assign bus.dout_vld          = (state_q == ST_OUT);
  assign bus.dout              = (state_q == ST_OUT) ? sat : '0;
  assign bus.dout_last         = (state_q == ST_OUT) && (cnt_q == CNT_W'(BLK_SIZE - 1));

endmodule
